// File: rtl/game_pkg.sv
// Shared definitions for the player combat slice: FSM state codes, column codes
// and health sizing.
package game_pkg;

  localparam int HEALTH_W           = 4;
  localparam int DEFAULT_MAX_HEALTH = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PUNCH = 3'd1,
    DODGE = 3'd2,
    STUN  = 3'd3,
    KO    = 3'd4,
    WIN   = 3'd5
  } state_t;

  localparam logic [1:0] POS_NONE = 2'b00;
  localparam logic [1:0] POS_L    = 2'b01;
  localparam logic [1:0] POS_M    = 2'b10;
  localparam logic [1:0] POS_R    = 2'b11;

endpackage

// File: rtl/player_combat_if.sv
// Bundle between the player combat resolver, the button/enemy side that feeds it
// and the consumers of its state (enemy controller, VGA draw logic).
interface player_combat_if;
  import game_pkg::*;

  logic                punch;
  logic                dodge_left;
  logic                dodge_right;
  logic [1:0]          enemy_x_pos;
  logic                enemy_attack;
  logic                enemy_dead;
  logic [1:0]          player_x_pos;
  logic [2:0]          player_state;
  logic [HEALTH_W-1:0] enemy_health;
  logic [HEALTH_W-1:0] player_health;
  logic                hit_landed;
  logic                player_hit;
  logic                game_over;

  modport master (
    output punch, dodge_left, dodge_right, enemy_x_pos, enemy_attack, enemy_dead,
    input  player_x_pos, player_state, enemy_health, player_health,
           hit_landed, player_hit, game_over
  );

  modport slave (
    input  punch, dodge_left, dodge_right, enemy_x_pos, enemy_attack, enemy_dead,
    output player_x_pos, player_state, enemy_health, player_health,
           hit_landed, player_hit, game_over
  );

endinterface

// File: rtl/sat_health.sv
// Saturating health counter: loads MAX_HEALTH, decrements by 1 or 2 without
// wrapping, can be frozen, and flags zero.
module sat_health
  import game_pkg::*;
#(
  parameter int MAX_HEALTH = DEFAULT_MAX_HEALTH
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic                dec,
  input  logic                dec_two,
  input  logic                freeze,
  output logic [HEALTH_W-1:0] value,
  output logic                zero
);

  logic [HEALTH_W-1:0] value_reg;
  logic [HEALTH_W-1:0] amount;

  assign amount = dec_two ? HEALTH_W'(2) : HEALTH_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value_reg <= HEALTH_W'(MAX_HEALTH);
    end else if (load) begin
      value_reg <= HEALTH_W'(MAX_HEALTH);
    end else if (!freeze && (dec || dec_two)) begin
      value_reg <= (value_reg <= amount) ? '0 : value_reg - amount;
    end
  end

  assign value = value_reg;
  assign zero  = (value_reg == '0);

endmodule

// File: rtl/player_combat.sv
// Player-side combat resolver: punch/dodge/stun/KO sequencing and both health
// counters. Optional counter-punch window enabled by defining COUNTER_PUNCH_EN.
module player_combat
  import game_pkg::*;
#(
  parameter int MAX_HEALTH   = DEFAULT_MAX_HEALTH,
  parameter int PUNCH_CYCLES = 4,
  parameter int DODGE_CYCLES = 8,
  parameter int STUN_CYCLES  = 16
`ifdef COUNTER_PUNCH_EN
  , parameter int COUNTER_WINDOW = 32
`endif
) (
  input logic            clock,
  input logic            reset_n,
  player_combat_if.slave bus
);

  localparam int PD_MAX  = (PUNCH_CYCLES > DODGE_CYCLES) ? PUNCH_CYCLES : DODGE_CYCLES;
  localparam int CNT_MAX = (PD_MAX > STUN_CYCLES) ? PD_MAX : STUN_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [1:0]          x_pos_reg;
  logic                hit_landed_reg;
  logic                player_hit_reg;
  logic                game_over_reg;

  logic [HEALTH_W-1:0] player_health;
  logic [HEALTH_W-1:0] enemy_health;
  logic                player_zero;
  logic                enemy_zero;

  logic frozen;
  logic terminal_now;
  logic attacked;
  logic punch_resolve;
  logic counter_hit;

  // Terminal checks look at the registered healths, so a killing blow shows up
  // as KO/WIN one cycle after the health reaches zero.
  assign frozen        = (state_reg == KO) || (state_reg == WIN);
  assign terminal_now  = !frozen && (enemy_zero || bus.enemy_dead || player_zero);
  assign attacked      = !frozen && !terminal_now && bus.enemy_attack &&
                         ((state_reg == IDLE) || (state_reg == PUNCH));
  // A strike in the resolve cycle wins over the punch: no enemy damage then.
  assign punch_resolve = !frozen && !terminal_now && !bus.enemy_attack &&
                         (state_reg == PUNCH) && (cnt_reg == '0) &&
                         (bus.enemy_x_pos == POS_M);

`ifdef COUNTER_PUNCH_EN
  localparam int WIN_W = $clog2(COUNTER_WINDOW + 1);

  logic [WIN_W-1:0] window_reg;
  logic             armed_reg;

  assign counter_hit = punch_resolve && (window_reg != '0);

  // A strike absorbed while dodging arms the window; it opens when the dodge ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      window_reg <= '0;
      armed_reg  <= 1'b0;
    end else if (attacked || counter_hit) begin
      window_reg <= '0;
      armed_reg  <= 1'b0;
    end else if (!terminal_now && (state_reg == DODGE) && (cnt_reg == '0) &&
                 (armed_reg || bus.enemy_attack)) begin
      window_reg <= WIN_W'(COUNTER_WINDOW);
      armed_reg  <= 1'b0;
    end else begin
      if ((state_reg == DODGE) && bus.enemy_attack) begin
        armed_reg <= 1'b1;
      end
      if (window_reg != '0) begin
        window_reg <= window_reg - WIN_W'(1);
      end
    end
  end
`else
  assign counter_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      x_pos_reg      <= POS_M;
      hit_landed_reg <= 1'b0;
      player_hit_reg <= 1'b0;
      game_over_reg  <= 1'b0;
    end else begin
      hit_landed_reg <= punch_resolve;
      player_hit_reg <= attacked;
      if (terminal_now) begin
        state_reg     <= (enemy_zero || bus.enemy_dead) ? WIN : KO;
        cnt_reg       <= '0;
        x_pos_reg     <= POS_M;
        game_over_reg <= 1'b1;
      end else begin
        case (state_reg)
          IDLE: begin
            if (attacked) begin
              state_reg <= STUN;
              cnt_reg   <= CNT_W'(STUN_CYCLES - 1);
            end else if (bus.dodge_left) begin
              state_reg <= DODGE;
              x_pos_reg <= POS_L;
              cnt_reg   <= CNT_W'(DODGE_CYCLES - 1);
            end else if (bus.dodge_right) begin
              state_reg <= DODGE;
              x_pos_reg <= POS_R;
              cnt_reg   <= CNT_W'(DODGE_CYCLES - 1);
            end else if (bus.punch) begin
              state_reg <= PUNCH;
              cnt_reg   <= CNT_W'(PUNCH_CYCLES - 1);
            end
          end
          PUNCH: begin
            if (attacked) begin
              state_reg <= STUN;
              cnt_reg   <= CNT_W'(STUN_CYCLES - 1);
            end else if (cnt_reg == '0) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          DODGE: begin
            if (cnt_reg == '0) begin
              state_reg <= IDLE;
              x_pos_reg <= POS_M;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          STUN: begin
            if (cnt_reg == '0) begin
              state_reg <= IDLE;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          KO, WIN: begin
            state_reg <= state_reg;
          end
          default: begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            x_pos_reg <= POS_M;
          end
        endcase
      end
    end
  end

  sat_health #(.MAX_HEALTH(MAX_HEALTH)) player_hp (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (1'b0),
    .dec     (attacked),
    .dec_two (1'b0),
    .freeze  (frozen),
    .value   (player_health),
    .zero    (player_zero)
  );

  sat_health #(.MAX_HEALTH(MAX_HEALTH)) enemy_hp (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (1'b0),
    .dec     (punch_resolve),
    .dec_two (counter_hit),
    .freeze  (frozen),
    .value   (enemy_health),
    .zero    (enemy_zero)
  );

  assign bus.player_x_pos  = x_pos_reg;
  assign bus.player_state  = state_reg;
  assign bus.enemy_health  = enemy_health;
  assign bus.player_health = player_health;
  assign bus.hit_landed    = hit_landed_reg;
  assign bus.player_hit    = player_hit_reg;
  assign bus.game_over     = game_over_reg;

endmodule

// File: tb/tb_player_combat.sv
// Directed bench for player_combat: expectations are queued when stimulus is
// applied and popped when the corresponding output is sampled.
module tb_player_combat;
  import game_pkg::*;

`ifdef COUNTER_PUNCH_EN
  localparam int COUNTER_DMG = 2;
`else
  localparam int COUNTER_DMG = 1;
`endif

  typedef struct {
    string tag;
    int    value;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   model_eh = 15;
  int   model_ph = 15;
  exp_t sb[$];

  always #5 clock = ~clock;

  player_combat_if bus ();

  player_combat dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input string tag, input int value);
    exp_t e;
    e.tag = tag;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] observed);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%0d expected=<nothing queued>", tag, observed);
    end else begin
      e = sb.pop_front();
      assert (observed === 32'(e.value) && tag == e.tag) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d (queued as %s)", tag, observed, e.value, e.tag);
      end
    end
    $display("check %-14s observed=%0d", tag, observed);
  endtask

  task automatic check_now(input string tag, input logic [31:0] observed, input int value);
    push(tag, value);
    pop_check(tag, observed);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    bus.punch = 1'b0;
    bus.dodge_left = 1'b0;
    bus.dodge_right = 1'b0;
    bus.enemy_x_pos = POS_M;
    bus.enemy_attack = 1'b0;
    bus.enemy_dead = 1'b0;
    reset_n = 1'b0;
    step(3);

    // reset values
    check_now("rst_state", 32'(bus.player_state), 0);
    check_now("rst_xpos", 32'(bus.player_x_pos), 2);
    check_now("rst_ph", 32'(bus.player_health), 15);
    check_now("rst_eh", 32'(bus.enemy_health), 15);
    check_now("rst_pulses", 32'({bus.hit_landed, bus.player_hit}), 0);
    check_now("rst_gameover", 32'(bus.game_over), 0);
    reset_n = 1'b1;
    step(1);
    check_now("idle_stay", 32'(bus.player_state), 0);

    // punch with enemy in the middle lands after PUNCH_CYCLES
    bus.punch = 1'b1;
    push("p1_enter", 1);
    step(1);
    bus.punch = 1'b0;
    pop_check("p1_enter", 32'(bus.player_state));
    step(3);
    check_now("p1_still", 32'(bus.player_state), 1);
    check_now("p1_early_hit", 32'(bus.hit_landed), 0);
    model_eh = model_eh - 1;
    push("p1_hit", 1);
    push("p1_eh", model_eh);
    push("p1_idle", 0);
    step(1);
    pop_check("p1_hit", 32'(bus.hit_landed));
    pop_check("p1_eh", 32'(bus.enemy_health));
    pop_check("p1_idle", 32'(bus.player_state));
    step(1);
    check_now("p1_pulse_clr", 32'(bus.hit_landed), 0);

    // punch with enemy on the left misses
    bus.enemy_x_pos = POS_L;
    bus.punch = 1'b1;
    step(1);
    bus.punch = 1'b0;
    step(4);
    check_now("p2_idle", 32'(bus.player_state), 0);
    check_now("p2_nohit", 32'(bus.hit_landed), 0);
    check_now("p2_eh", 32'(bus.enemy_health), model_eh);
    bus.enemy_x_pos = POS_M;

    // dodge left absorbs a strike
    bus.dodge_left = 1'b1;
    step(1);
    bus.dodge_left = 1'b0;
    check_now("d_state", 32'(bus.player_state), 2);
    check_now("d_xpos", 32'(bus.player_x_pos), 1);
    step(2);
    bus.enemy_attack = 1'b1;
    step(1);
    bus.enemy_attack = 1'b0;
    check_now("d_nohit", 32'(bus.player_hit), 0);
    step(4);
    check_now("d_xpos_last", 32'(bus.player_x_pos), 1);
    check_now("d_ph", 32'(bus.player_health), model_ph);
    step(1);
    check_now("d_exit_state", 32'(bus.player_state), 0);
    check_now("d_exit_xpos", 32'(bus.player_x_pos), 2);

    // strike on the punch resolve cycle: stun, no enemy damage
    bus.punch = 1'b1;
    step(1);
    bus.punch = 1'b0;
    step(3);
    bus.enemy_attack = 1'b1;
    model_ph = model_ph - 1;
    step(1);
    bus.enemy_attack = 1'b0;
    check_now("s_phit", 32'(bus.player_hit), 1);
    check_now("s_nohit", 32'(bus.hit_landed), 0);
    check_now("s_state", 32'(bus.player_state), 3);
    check_now("s_ph", 32'(bus.player_health), model_ph);
    check_now("s_eh", 32'(bus.enemy_health), model_eh);
    step(15);
    check_now("s_still", 32'(bus.player_state), 3);
    step(1);
    check_now("s_exit", 32'(bus.player_state), 0);

    // all requests together: dodge_left wins; absorbed strike then a punch
    bus.dodge_left = 1'b1;
    bus.dodge_right = 1'b1;
    bus.punch = 1'b1;
    step(1);
    bus.dodge_left = 1'b0;
    bus.dodge_right = 1'b0;
    bus.punch = 1'b0;
    check_now("prio_state", 32'(bus.player_state), 2);
    check_now("prio_xpos", 32'(bus.player_x_pos), 1);
    step(2);
    bus.enemy_attack = 1'b1;
    step(1);
    bus.enemy_attack = 1'b0;
    step(5);
    check_now("c_exit", 32'(bus.player_state), 0);
    bus.punch = 1'b1;
    step(1);
    bus.punch = 1'b0;
    step(4);
    model_eh = model_eh - COUNTER_DMG;
    check_now("c_hit", 32'(bus.hit_landed), 1);
    check_now("c_eh", 32'(bus.enemy_health), model_eh);

    // held punch re-triggers until the enemy is out of health
    bus.punch = 1'b1;
    hits = 0;
    for (int i = 0; i < 400 && bus.player_state != WIN; i++) begin
      step(1);
      if (bus.hit_landed === 1'b1) hits++;
    end
    check_now("win_hits", 32'(hits), model_eh);
    check_now("win_state", 32'(bus.player_state), 5);
    check_now("win_eh", 32'(bus.enemy_health), 0);
    check_now("win_gameover", 32'(bus.game_over), 1);
    check_now("win_xpos", 32'(bus.player_x_pos), 2);
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      bus.enemy_attack = (i == 5);
      step(1);
      if (bus.hit_landed === 1'b1 || bus.player_hit === 1'b1) hits++;
    end
    bus.punch = 1'b0;
    bus.enemy_attack = 1'b0;
    check_now("win_frozen", 32'(hits), 0);
    check_now("win_hold", 32'(bus.player_state), 5);
    check_now("win_ph", 32'(bus.player_health), model_ph);

    // asynchronous reset mid-cycle
    #3;
    reset_n = 1'b0;
    #1;
    check_now("arst_state", 32'(bus.player_state), 0);
    check_now("arst_eh", 32'(bus.enemy_health), 15);
    check_now("arst_gameover", 32'(bus.game_over), 0);
    step(2);
    reset_n = 1'b1;
    model_eh = 15;
    model_ph = 15;

    // fifteen strikes knock the player out
    for (int i = 0; i < 15; i++) begin
      bus.enemy_attack = 1'b1;
      step(1);
      bus.enemy_attack = 1'b0;
      model_ph = model_ph - 1;
      if (i < 14) step(16);
    end
    check_now("ko_ph", 32'(bus.player_health), model_ph);
    step(1);
    check_now("ko_state", 32'(bus.player_state), 4);
    check_now("ko_gameover", 32'(bus.game_over), 1);
    check_now("ko_eh", 32'(bus.enemy_health), 15);

    // enemy_dead forces WIN
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
    bus.enemy_dead = 1'b1;
    step(1);
    bus.enemy_dead = 1'b0;
    check_now("dead_state", 32'(bus.player_state), 5);
    check_now("dead_gameover", 32'(bus.game_over), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
